// File: rtl/fp_store_pkg.sv
// Shared defaults and the clear-engine state type for the fingerprint template store.
package fp_store_pkg;

  localparam int ROW_W_DEF = 256;
  localparam int ROWS_DEF  = 256;
  localparam int SLOTS_DEF = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/fp_bank_dp.sv
// One template slot bank: dual-port RAM with 1-cycle registered reads on both ports.
// Port A writes (and reads when a_en), port B is read-only. Read-before-write on a
// same-address collision, so both ports return the old row. Each read register only
// updates on its own enable, so it holds its value between reads.
module fp_bank_dp
  import fp_store_pkg::*;
#(
  parameter int ROW_W  = ROW_W_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int ADDR_W = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ROW_W-1:0]  a_wdata,
  output logic [ROW_W-1:0]  a_q,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [ROW_W-1:0]  b_q
);

  logic [ROW_W-1:0] mem_r [ROWS];

  // Storage array: the contents are never reset.
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem_r[a_addr] <= a_wdata;
    end
  end

  // Port A read register: it holds its value when the port is not reading.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
    end else if (a_en) begin
      a_q <= mem_r[a_addr];
    end
  end

  // Port B read register: it serves search reads only.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q <= '0;
    end else if (b_en) begin
      b_q <= mem_r[b_addr];
    end
  end

endmodule

// File: rtl/fp_store_mc.sv
// Multi-slot fingerprint template store with these functions:
//   - a row loader;
//   - a video read port and a search read port, each returning two slots per access;
//   - a per-slot zero-fill clear engine;
//   - per-slot valid flags.
// Port A of each bank is shared between video, clear and write, with priority in that order.
// Optional feature: define FP_STORE_BYPASS_EN so that a search read of a row that is being
// written or cleared in the same cycle returns the new row. The check is done per half.
module fp_store_mc
  import fp_store_pkg::*;
#(
  parameter int ROW_W  = ROW_W_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int SLOTS  = SLOTS_DEF,
  parameter int ADDR_W = $clog2(ROWS),
  parameter int SLOT_W = $clog2(SLOTS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [SLOT_W-1:0]  wr_slot,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [ROW_W-1:0]   wr_data,
  input  logic               wr_last,
  input  logic               clr_req,
  input  logic [SLOT_W-1:0]  clr_slot,
  output logic               clr_busy,
  input  logic               vid_rd_en,
  input  logic [SLOT_W-1:0]  vid_slot_a,
  input  logic [SLOT_W-1:0]  vid_slot_b,
  input  logic [ADDR_W-1:0]  vid_addr,
  output logic [2*ROW_W-1:0] vid_data,
  output logic               vid_dvalid,
  input  logic               srch_rd_en,
  input  logic [SLOT_W-1:0]  srch_slot_a,
  input  logic [SLOT_W-1:0]  srch_slot_b,
  input  logic [ADDR_W-1:0]  srch_addr,
  output logic [2*ROW_W-1:0] srch_data,
  output logic               srch_dvalid,
  output logic [SLOTS-1:0]   slot_valid
);

  clr_state_t        state_r, state_nx_s;
  logic [ADDR_W-1:0] cnt_r, cnt_nx_s;
  logic [SLOT_W-1:0] cslot_r, cslot_nx_s;
  logic              up_r;

  logic              vid_blk_s, clr_hold_s, clr_wr_s, wr_acc_s, clr_acc_s;
  logic [SLOTS-1:0]  slot_valid_r, slot_valid_nx_s;

  logic [SLOTS-1:0]  pa_en_s, pa_we_s, pb_en_s;
  logic [ADDR_W-1:0] pa_addr_s  [SLOTS];
  logic [ROW_W-1:0]  pa_wdata_s [SLOTS];
  logic [ROW_W-1:0]  qa_s       [SLOTS];
  logic [ROW_W-1:0]  qb_s       [SLOTS];

  logic [SLOT_W-1:0] vsa_r, vsb_r, ssa_r, ssb_r;
  logic              vid_dvalid_r, srch_dvalid_r;
  logic [ROW_W-1:0]  vid_lo_s, vid_hi_s, srch_lo_raw_s, srch_hi_raw_s, srch_lo_s, srch_hi_s;

  // A write is blocked if the video port is reading the target slot. A slot with an index
  // of SLOTS or more matches no bank, so a write to it is accepted and then dropped.
  assign vid_blk_s  = vid_rd_en & ((wr_slot == vid_slot_a) | (wr_slot == vid_slot_b));
  assign wr_ready   = up_r & ~rst & (state_r == ST_IDLE) & ~vid_blk_s;
  assign wr_acc_s   = wr_valid & wr_ready;
  assign clr_hold_s = vid_rd_en & ((cslot_r == vid_slot_a) | (cslot_r == vid_slot_b));
  assign clr_wr_s   = (state_r == ST_CLEAR) & ~clr_hold_s & ~rst;
  assign clr_acc_s  = clr_req & (state_r == ST_IDLE) & ~rst;
  assign clr_busy   = (state_r == ST_CLEAR);

  // Port-A arbitration for each bank (video, then clear, then write); search uses port B.
  always_comb begin
    for (int s = 0; s < SLOTS; s++) begin
      pa_en_s[s]    = 1'b0;
      pa_we_s[s]    = 1'b0;
      pa_addr_s[s]  = '0;
      pa_wdata_s[s] = '0;
      if (vid_rd_en && !rst &&
          ((vid_slot_a == SLOT_W'(s)) || (vid_slot_b == SLOT_W'(s)))) begin
        pa_en_s[s]   = 1'b1;
        pa_addr_s[s] = vid_addr;
      end else if (clr_wr_s && (cslot_r == SLOT_W'(s))) begin
        pa_we_s[s]   = 1'b1;
        pa_addr_s[s] = cnt_r;
      end else if (wr_acc_s && (wr_slot == SLOT_W'(s))) begin
        pa_we_s[s]    = 1'b1;
        pa_addr_s[s]  = wr_addr;
        pa_wdata_s[s] = wr_data;
      end else begin
        pa_en_s[s] = 1'b0;
      end
      pb_en_s[s] = srch_rd_en & ~rst &
                   ((srch_slot_a == SLOT_W'(s)) | (srch_slot_b == SLOT_W'(s)));
    end
  end

  genvar g;
  generate
    for (g = 0; g < SLOTS; g++) begin : g_bank
      fp_bank_dp #(
        .ROW_W  (ROW_W),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
      ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .a_en    (pa_en_s[g]),
        .a_we    (pa_we_s[g]),
        .a_addr  (pa_addr_s[g]),
        .a_wdata (pa_wdata_s[g]),
        .a_q     (qa_s[g]),
        .b_en    (pb_en_s[g]),
        .b_addr  (srch_addr),
        .b_q     (qb_s[g])
      );
    end
  endgenerate

  // Clear-engine state register. up_r releases wr_ready one cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      cslot_r <= '0;
      up_r    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      cslot_r <= cslot_nx_s;
      up_r    <= 1'b1;
    end
  end

  // Clear-engine next state. It writes one zero row per cycle and stalls while video reads
  // the slot being cleared.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    cslot_nx_s = cslot_r;
    case (state_r)
      ST_IDLE: begin
        if (clr_req) begin
          state_nx_s = ST_CLEAR;
          cnt_nx_s   = '0;
          cslot_nx_s = clr_slot;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_hold_s) begin
          cnt_nx_s = cnt_r;
        end else if (cnt_r == ADDR_W'(ROWS - 1)) begin
          state_nx_s = ST_IDLE;
        end else begin
          cnt_nx_s = cnt_r + ADDR_W'(1);
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Next slot-valid value. An accepted write sets the bit to wr_last. An accepted clear
  // zeroes the bit afterwards, so the clear wins over a same-cycle write.
  always_comb begin
    slot_valid_nx_s = slot_valid_r;
    for (int s = 0; s < SLOTS; s++) begin
      if (wr_acc_s && (wr_slot == SLOT_W'(s))) begin
        slot_valid_nx_s[s] = wr_last;
      end else begin
        slot_valid_nx_s[s] = slot_valid_r[s];
      end
      if (clr_acc_s && (clr_slot == SLOT_W'(s))) begin
        slot_valid_nx_s[s] = 1'b0;
      end else begin
        slot_valid_nx_s[s] = slot_valid_nx_s[s];
      end
    end
  end

  // Slot-valid flags register.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_r <= '0;
    end else begin
      slot_valid_r <= slot_valid_nx_s;
    end
  end

  // Read-side pipeline. The slot selects are captured together with the bank reads, so the
  // output muxes hold the last data while no read is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vid_dvalid_r  <= 1'b0;
      srch_dvalid_r <= 1'b0;
      vsa_r         <= '0;
      vsb_r         <= '0;
      ssa_r         <= '0;
      ssb_r         <= '0;
    end else begin
      vid_dvalid_r  <= vid_rd_en;
      srch_dvalid_r <= srch_rd_en;
      if (vid_rd_en) begin
        vsa_r <= vid_slot_a;
        vsb_r <= vid_slot_b;
      end else begin
        vsa_r <= vsa_r;
        vsb_r <= vsb_r;
      end
      if (srch_rd_en) begin
        ssa_r <= srch_slot_a;
        ssb_r <= srch_slot_b;
      end else begin
        ssa_r <= ssa_r;
        ssb_r <= ssb_r;
      end
    end
  end

  // Output half muxes. A slot select that matches no bank gives zero.
  always_comb begin
    vid_lo_s      = '0;
    vid_hi_s      = '0;
    srch_lo_raw_s = '0;
    srch_hi_raw_s = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (vsa_r == SLOT_W'(s)) vid_lo_s = qa_s[s];
      else vid_lo_s = vid_lo_s;
      if (vsb_r == SLOT_W'(s)) vid_hi_s = qa_s[s];
      else vid_hi_s = vid_hi_s;
      if (ssa_r == SLOT_W'(s)) srch_lo_raw_s = qb_s[s];
      else srch_lo_raw_s = srch_lo_raw_s;
      if (ssb_r == SLOT_W'(s)) srch_hi_raw_s = qb_s[s];
      else srch_hi_raw_s = srch_hi_raw_s;
    end
  end

`ifdef FP_STORE_BYPASS_EN
  logic             fwd_lo_hit_s, fwd_hi_hit_s;
  logic [ROW_W-1:0] fwd_lo_data_s, fwd_hi_data_s;
  logic             fwd_lo_r, fwd_hi_r;
  logic [ROW_W-1:0] fwd_lo_q_r, fwd_hi_q_r;

  // Detect a search half that targets the row being written on port A of the same bank.
  always_comb begin
    fwd_lo_hit_s  = 1'b0;
    fwd_hi_hit_s  = 1'b0;
    fwd_lo_data_s = '0;
    fwd_hi_data_s = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (pa_we_s[s] && (pa_addr_s[s] == srch_addr) && (srch_slot_a == SLOT_W'(s))) begin
        fwd_lo_hit_s  = 1'b1;
        fwd_lo_data_s = pa_wdata_s[s];
      end else begin
        fwd_lo_hit_s = fwd_lo_hit_s;
      end
      if (pa_we_s[s] && (pa_addr_s[s] == srch_addr) && (srch_slot_b == SLOT_W'(s))) begin
        fwd_hi_hit_s  = 1'b1;
        fwd_hi_data_s = pa_wdata_s[s];
      end else begin
        fwd_hi_hit_s = fwd_hi_hit_s;
      end
    end
  end

  // Capture the forwarded rows alongside the search read they replace.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_lo_r   <= 1'b0;
      fwd_hi_r   <= 1'b0;
      fwd_lo_q_r <= '0;
      fwd_hi_q_r <= '0;
    end else if (srch_rd_en) begin
      fwd_lo_r   <= fwd_lo_hit_s;
      fwd_hi_r   <= fwd_hi_hit_s;
      fwd_lo_q_r <= fwd_lo_data_s;
      fwd_hi_q_r <= fwd_hi_data_s;
    end else begin
      fwd_lo_r <= fwd_lo_r;
      fwd_hi_r <= fwd_hi_r;
    end
  end

  assign srch_lo_s = fwd_lo_r ? fwd_lo_q_r : srch_lo_raw_s;
  assign srch_hi_s = fwd_hi_r ? fwd_hi_q_r : srch_hi_raw_s;
`else
  assign srch_lo_s = srch_lo_raw_s;
  assign srch_hi_s = srch_hi_raw_s;
`endif

  assign vid_data    = {vid_hi_s, vid_lo_s};
  assign srch_data   = {srch_hi_s, srch_lo_s};
  assign vid_dvalid  = vid_dvalid_r;
  assign srch_dvalid = srch_dvalid_r;
  assign slot_valid  = slot_valid_r;

endmodule

// File: tb/tb_fp_store_mc.sv
// Self-checking bench for fp_store_mc. A behavioural model (template array, valid flags,
// clear progress) predicts every output each cycle. The bench runs an arbitration vector
// table, hand sequences for the multi-cycle corners and a randomized traffic phase.
module tb_fp_store_mc;

  localparam int ROW_W  = 256;
  localparam int ROWS   = 256;
  localparam int SLOTS  = 4;
  localparam int ADDR_W = 8;
  localparam int SLOT_W = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               wr_valid, wr_ready, wr_last;
  logic [SLOT_W-1:0]  wr_slot;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ROW_W-1:0]   wr_data;
  logic               clr_req, clr_busy;
  logic [SLOT_W-1:0]  clr_slot;
  logic               vid_rd_en, vid_dvalid;
  logic [SLOT_W-1:0]  vid_slot_a, vid_slot_b;
  logic [ADDR_W-1:0]  vid_addr;
  logic [2*ROW_W-1:0] vid_data;
  logic               srch_rd_en, srch_dvalid;
  logic [SLOT_W-1:0]  srch_slot_a, srch_slot_b;
  logic [ADDR_W-1:0]  srch_addr;
  logic [2*ROW_W-1:0] srch_data;
  logic [SLOTS-1:0]   slot_valid;

  fp_store_mc #(.ROW_W(ROW_W), .ROWS(ROWS), .SLOTS(SLOTS)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_slot(wr_slot), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_last(wr_last),
    .clr_req(clr_req), .clr_slot(clr_slot), .clr_busy(clr_busy),
    .vid_rd_en(vid_rd_en), .vid_slot_a(vid_slot_a), .vid_slot_b(vid_slot_b),
    .vid_addr(vid_addr), .vid_data(vid_data), .vid_dvalid(vid_dvalid),
    .srch_rd_en(srch_rd_en), .srch_slot_a(srch_slot_a), .srch_slot_b(srch_slot_b),
    .srch_addr(srch_addr), .srch_data(srch_data), .srch_dvalid(srch_dvalid),
    .slot_valid(slot_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [ROW_W-1:0]   ref_mem [SLOTS][ROWS];
  logic [SLOTS-1:0]   ref_valid = '0;
  logic               ref_up = 1'b0, ref_busy = 1'b0;
  int                 ref_cnt = 0;
  int                 ref_cslot = 0;
  logic               exp_vdv = 1'b0, exp_sdv = 1'b0;
  logic [2*ROW_W-1:0] exp_vd = '0, exp_sd = '0;

  typedef struct {
    logic             vid;
    logic [SLOT_W-1:0] va;
    logic [SLOT_W-1:0] vb;
    logic [SLOT_W-1:0] ws;
    logic             rdy;
  } arb_vec_t;
  arb_vec_t arb_tbl [6];

  task automatic chk(input string name, input logic [2*ROW_W-1:0] act,
                     input logic [2*ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] rdm(input logic [SLOT_W-1:0] s,
                                           input logic [ADDR_W-1:0] a);
    if (int'(s) < SLOTS) return ref_mem[s][a];
    else return '0;
  endfunction

  task automatic idle_inputs();
    rst = 1'b0; wr_valid = 1'b0; wr_slot = '0; wr_addr = '0; wr_data = '0; wr_last = 1'b0;
    clr_req = 1'b0; clr_slot = '0;
    vid_rd_en = 1'b0; vid_slot_a = '0; vid_slot_b = '0; vid_addr = '0;
    srch_rd_en = 1'b0; srch_slot_a = '0; srch_slot_b = '0; srch_addr = '0;
  endtask

  // One clock cycle with the current inputs. The model predicts wr_ready before the edge
  // and all registered outputs after it.
  task automatic step();
    logic exp_rdy, acc, hold, clr_wr;
    logic [2*ROW_W-1:0] nv, ns;
    #1;
    exp_rdy = !rst && ref_up && !ref_busy &&
              !(vid_rd_en && (wr_slot == vid_slot_a || wr_slot == vid_slot_b));
    chk("wr_ready", wr_ready, exp_rdy);
    acc    = wr_valid && exp_rdy;
    hold   = ref_busy && vid_rd_en &&
             (int'(vid_slot_a) == ref_cslot || int'(vid_slot_b) == ref_cslot);
    clr_wr = ref_busy && !hold && !rst;
    nv = {rdm(vid_slot_b, vid_addr), rdm(vid_slot_a, vid_addr)};
    ns = {rdm(srch_slot_b, srch_addr), rdm(srch_slot_a, srch_addr)};
    if (clr_wr && ref_cslot < SLOTS) ref_mem[ref_cslot][ref_cnt] = '0;
    if (acc && int'(wr_slot) < SLOTS) ref_mem[wr_slot][wr_addr] = wr_data;
`ifdef FP_STORE_BYPASS_EN
    ns = {rdm(srch_slot_b, srch_addr), rdm(srch_slot_a, srch_addr)};
`endif
    if (rst) begin
      ref_valid = '0; ref_busy = 1'b0; ref_cnt = 0;
      exp_vdv = 1'b0; exp_sdv = 1'b0; exp_vd = '0; exp_sd = '0;
    end else begin
      if (acc && int'(wr_slot) < SLOTS) ref_valid[wr_slot] = wr_last;
      if (!ref_busy && clr_req) begin
        ref_busy = 1'b1; ref_cnt = 0; ref_cslot = int'(clr_slot);
        if (int'(clr_slot) < SLOTS) ref_valid[clr_slot] = 1'b0;
      end else if (clr_wr) begin
        if (ref_cnt == ROWS - 1) ref_busy = 1'b0;
        else ref_cnt++;
      end
      exp_vdv = vid_rd_en;
      exp_sdv = srch_rd_en;
      if (vid_rd_en) exp_vd = nv;
      if (srch_rd_en) exp_sd = ns;
    end
    ref_up = !rst;
    @(posedge clk);
    #1;
    chk("clr_busy", clr_busy, ref_busy);
    chk("slot_valid", slot_valid, ref_valid);
    chk("vid_dvalid", vid_dvalid, exp_vdv);
    chk("srch_dvalid", srch_dvalid, exp_sdv);
    chk("vid_data", vid_data, exp_vd);
    chk("srch_data", srch_data, exp_sd);
  endtask

  task automatic write_row(input int s, input int a, input logic [ROW_W-1:0] d,
                           input logic last);
    wr_valid = 1'b1; wr_slot = SLOT_W'(s); wr_addr = ADDR_W'(a); wr_data = d; wr_last = last;
    step();
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic clear_slot(input int s);
    clr_req = 1'b1; clr_slot = SLOT_W'(s);
    step();
    clr_req = 1'b0;
    repeat (ROWS) step();
  endtask

  initial begin
    logic [ROW_W-1:0] pat_a, pat_b, pat;
    int busy_cnt;
    arb_tbl[0] = '{1'b1, 2'd1, 2'd0, 2'd1, 1'b0};
    arb_tbl[1] = '{1'b1, 2'd1, 2'd0, 2'd3, 1'b1};
    arb_tbl[2] = '{1'b1, 2'd0, 2'd1, 2'd1, 1'b0};
    arb_tbl[3] = '{1'b0, 2'd1, 2'd1, 2'd1, 1'b1};
    arb_tbl[4] = '{1'b1, 2'd2, 2'd2, 2'd2, 1'b0};
    arb_tbl[5] = '{1'b1, 2'd3, 2'd2, 2'd0, 1'b1};

    // Reset
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    chk("rst_clr_busy", clr_busy, 1'b0);
    chk("rst_slot_valid", slot_valid, 4'b0000);
    chk("rst_vid_data", vid_data, '0);
    chk("rst_srch_dvalid", srch_dvalid, 1'b0);
    rst = 1'b0;
    step();
    #1 chk("ready_after_rst", wr_ready, 1'b1);

    // Zero every slot so that all model contents are known
    for (int s = 0; s < SLOTS; s++) clear_slot(s);

    // Load slot 2 with row index data and search row 7
    for (int r = 0; r < ROWS; r++) write_row(2, r, ROW_W'(r), (r == ROWS - 1));
    chk("load_slot_valid", slot_valid, 4'b0100);
    srch_rd_en = 1'b1; srch_slot_a = 2'd2; srch_slot_b = 2'd2; srch_addr = 8'd7;
    step();
    srch_rd_en = 1'b0;
    chk("srch_row7", srch_data, {256'd7, 256'd7});
    chk("srch_row7_dv", srch_dvalid, 1'b1);
    step();

    // Arbitration vector table
    for (int i = 0; i < 6; i++) begin
      vid_rd_en = arb_tbl[i].vid; vid_slot_a = arb_tbl[i].va; vid_slot_b = arb_tbl[i].vb;
      vid_addr = '0;
      wr_valid = 1'b1; wr_slot = arb_tbl[i].ws; wr_addr = ADDR_W'(10 + i);
      for (int k = 0; k < ROW_W / 32; k++) wr_data[k*32 +: 32] = $urandom;
      #1 chk($sformatf("arb_tbl_%0d", i), wr_ready, arb_tbl[i].rdy);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      srch_rd_en = 1'b1; srch_slot_a = arb_tbl[i].ws; srch_slot_b = arb_tbl[i].ws;
      srch_addr = ADDR_W'(10 + i);
      step();
    end
    idle_inputs();

    // Clear slot 2 with three colliding video reads
    clr_req = 1'b1; clr_slot = 2'd2;
    step();
    clr_req = 1'b0;
    busy_cnt = clr_busy ? 1 : 0;
    for (int n = 0; n < 400 && clr_busy; n++) begin
      vid_rd_en = (n == 10 || n == 50 || n == 51);
      vid_slot_a = 2'd2; vid_slot_b = 2'd0; vid_addr = n[7:0];
      step();
      if (clr_busy) busy_cnt++;
    end
    vid_rd_en = 1'b0;
    chk("clr_busy_cycles", busy_cnt, 259);
    chk("clr_slot_valid2", slot_valid[2], 1'b0);
    for (int r = 0; r < ROWS; r++) begin
      srch_rd_en = 1'b1; srch_slot_a = 2'd2; srch_slot_b = 2'd2; srch_addr = ADDR_W'(r);
      step();
      chk("clr_row_zero", srch_data, '0);
    end
    idle_inputs();

    // Search collides with a write to the same slot and row
    pat_a = {8{32'hA5A5_0001}};
    pat_b = {8{32'h5A5A_0002}};
    write_row(0, 5, pat_a, 1'b0);
    srch_rd_en = 1'b1; srch_slot_a = 2'd0; srch_slot_b = 2'd0; srch_addr = 8'd5;
    write_row(0, 5, pat_b, 1'b0);
    srch_rd_en = 1'b0;
`ifdef FP_STORE_BYPASS_EN
    chk("rdw_collision", srch_data, {pat_b, pat_b});
`else
    chk("rdw_collision", srch_data, {pat_a, pat_a});
`endif

    // wr_last handling on slot 1
    write_row(1, 0, '0, 1'b1);
    chk("last_sets_valid", slot_valid[1], 1'b1);
    for (int r = 0; r < ROWS; r++) write_row(1, r, ROW_W'(r + 1000), 1'b0);
    chk("no_last_valid1", slot_valid[1], 1'b0);
    write_row(1, 3, ROW_W'(77), 1'b1);
    chk("last_valid1", slot_valid[1], 1'b1);

    // Reset while the clear engine is at row 100
    pat = {8{32'hC0DE_0100}};
    for (int r = 98; r < 102; r++) write_row(3, r, pat, 1'b1);
    clr_req = 1'b1; clr_slot = 2'd3;
    step();
    clr_req = 1'b0;
    repeat (99) step();
    vid_rd_en = 1'b1; vid_slot_a = 2'd0; vid_slot_b = 2'd0;
    srch_rd_en = 1'b1; srch_slot_a = 2'd0; srch_slot_b = 2'd0;
    step();
    rst = 1'b1;
    step();
    chk("rst_mid_busy", clr_busy, 1'b0);
    chk("rst_mid_vdv", vid_dvalid, 1'b0);
    chk("rst_mid_sdv", srch_dvalid, 1'b0);
    chk("rst_mid_valid", slot_valid, 4'b0000);
    idle_inputs();
    step();
    #1 chk("rst_mid_ready", wr_ready, 1'b1);
    for (int r = 98; r < 102; r++) begin
      srch_rd_en = 1'b1; srch_slot_a = 2'd3; srch_slot_b = 2'd1; srch_addr = ADDR_W'(r);
      step();
    end
    idle_inputs();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_slot = SLOT_W'($urandom_range(0, SLOTS - 1));
      wr_addr = ADDR_W'($urandom_range(0, 7));
      for (int k = 0; k < ROW_W / 32; k++) wr_data[k*32 +: 32] = $urandom;
      wr_last = 1'($urandom_range(0, 1));
      clr_req = ($urandom_range(0, 199) == 0);
      clr_slot = SLOT_W'($urandom_range(0, SLOTS - 1));
      vid_rd_en = 1'($urandom_range(0, 1));
      vid_slot_a = SLOT_W'($urandom_range(0, SLOTS - 1));
      vid_slot_b = SLOT_W'($urandom_range(0, SLOTS - 1));
      vid_addr = ADDR_W'($urandom_range(0, 7));
      srch_rd_en = 1'($urandom_range(0, 1));
      srch_slot_a = SLOT_W'($urandom_range(0, SLOTS - 1));
      srch_slot_b = SLOT_W'($urandom_range(0, SLOTS - 1));
      srch_addr = ADDR_W'($urandom_range(0, 7));
      step();
    end
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
